// File: rtl/bsm_pkg.sv
// Shared types and helpers for the bit-serial multiply-accumulate unit.
// Holds the FSM state encoding, the width-field sizing and the width legality check.
package bsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to encode a width value in 0..max_w.
  function automatic int calc_cw(input int max_w);
    return $clog2(max_w + 1);
  endfunction

  function automatic logic width_legal(input int unsigned w, input int unsigned max_w);
    return (w != 0) && (w <= max_w);
  endfunction

endpackage

// File: rtl/bsm_idx_cnt.sv
// Nested i/j partial-product index counter: j runs fastest and wraps at wb-1, then i advances.
// Single-cycle step; no backpressure of its own, the owning FSM gates step.
module bsm_idx_cnt #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [CW-1:0] wa,
  input  logic [CW-1:0] wb,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic          last,
  output logic          a_msb,
  output logic          b_msb
);

  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;

  assign a_msb = (i_q == wa - 1'b1);
  assign b_msb = (j_q == wb - 1'b1);
  assign last  = a_msb && b_msb;
  assign i     = i_q;
  assign j     = j_q;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (load) begin
      i_d = '0;
      j_d = '0;
    end else if (step) begin
      if (b_msb) begin
        j_d = '0;
        i_d = i_q + 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/bsm_mac.sv
// Bit-serial MAC: one partial-product term per cycle, result wa*wb cycles after accept (illegal widths: next cycle).
// Result is held in DONE until out_ready; a new operation is accepted only in IDLE.
module bsm_mac
  import bsm_pkg::*;
#(
  parameter  int MAX_W = 16,
  parameter  int ACC_W = 40,
  localparam int CW    = calc_cw(MAX_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAX_W-1:0] a,
  input  logic [MAX_W-1:0] b,
  input  logic [CW-1:0]    wa,
  input  logic [CW-1:0]    wb,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [MAX_W-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]      wa_q, wa_d, wb_q, wb_d;
  logic               as_q, as_d, bs_q, bs_d;
  logic               err_q, err_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   prev_q, prev_d;

  logic               cnt_load, cnt_step;
  logic [CW-1:0]      idx_i, idx_j;
  logic               idx_last, idx_a_msb, idx_b_msb;

  logic               legal;
  logic               pp_bit, neg;
  logic [CW:0]        sh;
  logic [ACC_W-1:0]   term;

  bsm_idx_cnt #(.CW(CW)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .step  (cnt_step),
    .wa    (wa_q),
    .wb    (wb_q),
    .i     (idx_i),
    .j     (idx_j),
    .last  (idx_last),
    .a_msb (idx_a_msb),
    .b_msb (idx_b_msb)
  );

  assign legal = width_legal(32'(wa), MAX_W) && width_legal(32'(wb), MAX_W);

  // Bit select via mask keeps every operand bit live and avoids index-width mismatch.
  assign pp_bit = (|(a_q & (MAX_W'(1) << idx_i))) && (|(b_q & (MAX_W'(1) << idx_j)));
  assign sh     = {1'b0, idx_i} + {1'b0, idx_j};
  assign term   = {{(ACC_W-1){1'b0}}, pp_bit} << sh;
  // Sign-bit rows/columns carry negative weight in two's complement.
  assign neg    = (as_q && idx_a_msb) ^ (bs_q && idx_b_msb);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_err   = out_valid && err_q;
  assign out_data  = out_valid ? acc_q : prev_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    as_d     = as_q;
    bs_d     = bs_q;
    err_d    = err_q;
    acc_d    = acc_q;
    prev_d   = prev_q;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          wa_d     = wa;
          wb_d     = wb;
          as_d     = a_signed;
          bs_d     = b_signed;
          cnt_load = 1'b1;
          if (legal) begin
            err_d   = 1'b0;
            acc_d   = acc_en ? prev_q : '0;
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        cnt_step = 1'b1;
        acc_d    = neg ? (acc_q - term) : (acc_q + term);
        if (idx_last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          prev_d  = acc_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      as_q    <= 1'b0;
      bs_q    <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      as_q    <= as_d;
      bs_q    <= bs_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: tb/tb_bsm_mac.sv
// Self-checking bench for bsm_mac: directed cases plus randomized operations against an arithmetic model.
// Drives inputs #1 after the rising edge and samples there too.
module tb_bsm_mac;

  localparam int MAX_W = 16;
  localparam int ACC_W = 40;
  localparam int CW    = 5;
  localparam longint unsigned MASK = (64'd1 << ACC_W) - 64'd1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [MAX_W-1:0] a, b;
  logic [CW-1:0]    wa, wb;
  logic             a_signed, b_signed, acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_err;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;
  longint unsigned prev_model = 0;

  bsm_mac #(.MAX_W(MAX_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .wa        (wa),
    .wb        (wb),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value of the low w bits of x, as signed or unsigned integer.
  function automatic longint operand_val(input logic [MAX_W-1:0] x, input int w, input logic sgn);
    longint v;
    v = longint'(x) & ((longint'(1) << w) - 1);
    if (sgn && v[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  task automatic scramble_inputs();
    a        = MAX_W'($urandom);
    b        = MAX_W'($urandom);
    wa       = CW'($urandom);
    wb       = CW'($urandom);
    a_signed = 1'($urandom);
    b_signed = 1'($urandom);
    acc_en   = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [MAX_W-1:0] av, input logic [MAX_W-1:0] bv,
                        input int wav, input int wbv, input logic asv, input logic bsv,
                        input logic aen, input int hold);
    longint unsigned exp_data;
    logic            exp_err;
    int              exp_lat;
    int              lat;
    int              guard;
    logic            stable;
    if (wav < 1 || wav > MAX_W || wbv < 1 || wbv > MAX_W) begin
      exp_err  = 1'b1;
      exp_data = prev_model;
      exp_lat  = 0;
    end else begin
      exp_err  = 1'b0;
      exp_data = (longint'(aen ? prev_model : 0) +
                  operand_val(av, wav, asv) * operand_val(bv, wbv, bsv)) & MASK;
      exp_lat  = wav * wbv;
    end

    guard = 0;
    while (!in_ready && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);

    in_valid = 1'b1;
    a = av; b = bv; wa = CW'(wav); wb = CW'(wbv);
    a_signed = asv; b_signed = bsv; acc_en = aen;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();

    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " out_data"}, 64'(out_data), exp_data);
    chk({tag, " out_err"}, 64'(out_err), 64'(exp_err));

    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!(out_valid && !in_ready && busy && out_data == ACC_W'(exp_data) && out_err == exp_err))
        stable = 1'b0;
    end
    if (hold > 0) chk({tag, " held under backpressure"}, 64'(stable), 64'd1);

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " in_ready after handshake"}, 64'({in_ready, out_valid}), 64'b10);
    prev_model = exp_data;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    scramble_inputs();
    #1;
    chk("reset outputs", 64'({in_ready, out_valid, out_err, busy}), 64'b1000);
    chk("reset out_data", 64'(out_data), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op("unsigned 13x11", 16'd13, 16'd11, 4, 4, 1'b0, 1'b0, 1'b0, 10);
    run_op("signed -3x5", 16'hFFFD, 16'h0005, 4, 4, 1'b1, 1'b1, 1'b0, 0);
    run_op("mixed 0x80x0xFF", 16'h0080, 16'h00FF, 8, 8, 1'b1, 1'b0, 1'b0, 2);
    run_op("acc first 3x5", 16'd3, 16'd5, 3, 3, 1'b0, 1'b0, 1'b0, 0);
    run_op("acc second 7x2", 16'd7, 16'd2, 3, 3, 1'b0, 1'b0, 1'b1, 0);
    chk("accumulated value", prev_model, 64'd29);
    run_op("wa zero", 16'd9, 16'd9, 0, 4, 1'b0, 1'b0, 1'b0, 3);
    run_op("wb too wide", 16'd9, 16'd9, 4, 17, 1'b0, 1'b0, 1'b1, 0);
    run_op("width1 signed -1x-1", 16'd1, 16'd1, 1, 1, 1'b1, 1'b1, 1'b0, 0);
    run_op("full width signed min", 16'h8000, 16'h8000, 16, 16, 1'b1, 1'b1, 1'b1, 0);

    // Reset in the middle of a long operation.
    in_valid = 1'b1;
    a = 16'hFF; b = 16'hFF; wa = 5'd8; wb = 5'd8;
    a_signed = 1'b0; b_signed = 1'b0; acc_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid-run reset outputs", 64'({in_ready, out_valid, out_err, busy}), 64'b1000);
    chk("mid-run reset out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_model = 0;
    run_op("acc after reset 3x3", 16'd3, 16'd3, 2, 2, 1'b0, 1'b0, 1'b1, 0);

    for (int k = 0; k < 40; k++) begin
      int rwa, rwb;
      rwa = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(1, MAX_W);
      rwb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(1, MAX_W);
      if (rwa == 0 && rwb == 0) rwb = 1;
      run_op($sformatf("random op %0d", k), MAX_W'($urandom), MAX_W'($urandom), rwa, rwb,
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
